mux2_rr_arbiter: RTL and testbench
==================================

# mux2_rr_arbiter

Round-robin arbiter that shares one 2:1 data mux and one output register between two streaming requesters (A, B). Each requester presents packets as valid/ready beats with a last flag. The arbiter grants the shared path for a whole packet, drives the mux select, and registers the selected beat toward a single downstream valid/ready consumer. It sits between two producer datapaths and a single shared consumer stage.

## Interface
- DATAWIDTH, 8, width of a_data, b_data, d_data
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A beat valid
- a_data  in  DATAWIDTH  requester A beat data
- a_last  in  1  requester A final beat of packet
- a_ready  out  1  A beat accepted when a_valid && a_ready
- b_valid, b_data, b_last, b_ready  same as A, for requester B
- d_valid  out  1  output register holds a beat
- d_data  out  DATAWIDTH  registered beat data
- d_last  out  1  registered last flag
- d_ready  in  1  downstream accepts when d_valid && d_ready
- sel  out  1  mux select: 0 = A, 1 = B; registered
- busy  out  1  high in OWN_A or OWN_B

## Operation
- States: IDLE, OWN_A, OWN_B. Priority pointer prio: 0 = A preferred, 1 = B preferred.
- IDLE:
  - Only a_valid -> OWN_A. Only b_valid -> OWN_B.
  - Both valid -> grant the preferred requester per prio.
  - Neither -> stay in IDLE.
  - sel is updated on the grant edge.
- OWN_x:
  - x_ready = !d_valid || d_ready. The non-owner's ready is 0.
  - Ready is 0 in IDLE.
- Beat accept (x_valid && x_ready):
  - Loads d_data/d_last from the mux (sel = owner).
  - Sets d_valid.
- Output drain: d_ready with no new load clears d_valid.
- Simultaneous drain and load: the register takes the new beat and d_valid stays 1.
- Packet end: an accepted beat with x_last = 1 moves the state to IDLE on the same edge. prio flips to favor the other requester.
- Lock: the owner keeps the grant until its last beat is accepted, even if x_valid deasserts mid-packet. The other requester waits.
- Single-beat packets (last on the first beat) are legal.
- Data in the mux passes through; arithmetic is not applied. Width is DATAWIDTH end to end, with no truncation.

## Timing
- Reset (async assert, any state): state = IDLE, prio = 0, sel = 0, d_valid = 0, d_data = 0, d_last = 0, busy = 0, a_ready = b_ready = 0.
- Reset mid-packet: any beat in the register is discarded. The packet is not resumed.
- Reset release is synchronous to Clk. The first grant is possible on the first edge after Rst_n is high.
- Grant latency: x_valid high in IDLE at cycle N -> OWN_x and sel valid at N+1. x_ready is high at N+1 if the register is empty.
- Data latency: beat accepted at edge E -> appears on d_data/d_valid immediately after E.
- Throughput: 1 beat/cycle while d_ready = 1.
- Packet-to-packet gap: one IDLE cycle between packets (re-arbitration bubble).
- Backpressure: with d_ready = 0 and d_valid = 1, x_ready = 0. d_data/d_last hold stable until accepted.
- ready outputs are combinational from state, d_valid and d_ready. All other outputs are registered.

## Structure
- Shared package / include holds:
  - State encodings ST_IDLE = 2'd0, ST_OWN_A = 2'd1, ST_OWN_B = 2'd2.
  - The SEL_A = 1'b0 / SEL_B = 1'b1 constants.
- Sub-modules: two instances of the team's MUX2x1:
  - One with DATAWIDTH passed through, for data.
  - One with DATAWIDTH = 1, for last.
  - Both driven by sel.
- The FSM, prio and output register are in this module.

## Test plan
- Reset mid-packet:
  - Stimulus: assert Rst_n = 0 while in OWN_B with d_valid = 1.
  - Required response: all outputs are 0 immediately (asynchronously). After release, a_valid wins because prio = 0.
- Lone requester:
  - Stimulus: a_valid with 3 beats 0x11, 0x22, 0x33 (last on 0x33); d_ready = 1.
  - Required response: d_data shows 0x11/0x22/0x33 on consecutive cycles starting 2 cycles after a_valid. d_last is high only with 0x33. The state returns to IDLE and prio = 1.
- Contention:
  - Stimulus: a_valid and b_valid both high, each with 2-beat packets (A: 0xA0, 0xA1; B: 0xB0, 0xB1), starting from reset.
  - Required response: the A packet goes first. There is a one-cycle IDLE gap, then the B packet. b_ready = 0 throughout the A packet.
- Backpressure:
  - Stimulus: hold d_ready = 0 for 4 cycles after the first beat 0x5A is loaded.
  - Required response: d_data = 0x5A stays stable, a_ready = 0, and no beat is lost. On d_ready = 1 the next beat follows in the next cycle.
- Lock:
  - Stimulus: during OWN_A, deassert a_valid for 3 cycles while b_valid = 1.
  - Required response: the state stays OWN_A with sel = 0. B is granted only after A's last beat is accepted.
- Single-beat alternation:
  - Stimulus: A and B each continuously send 1-beat packets (last = 1).
  - Required response: grants alternate A, B, A, B. d_valid pulses every other cycle.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
//   state_e : arbiter ownership state (idle, A owns the path, B owns the path)
//   SEL_A/B : mux select encodings. The priority pointer reuses these values
//             to name the preferred requester.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_mux2x1.sv
// Plain 2:1 multiplexer used for the shared datapath.
//   sel  in  : SEL_A selects in0, SEL_B selects in1
//   in0  in  : DATAWIDTH-bit input for requester A
//   in1  in  : DATAWIDTH-bit input for requester B
//   out  out : selected input, passed through unchanged
module mux2x1
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 sel,
    input  logic [DATAWIDTH-1:0] in0,
    input  logic [DATAWIDTH-1:0] in1,
    output logic [DATAWIDTH-1:0] out
);

    assign out = (sel == SEL_B) ? in1 : in0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux and one output register between two
// packet streams (A, B). A grant covers a whole packet. The path is released
// when the owner's last beat is accepted, and the priority pointer then moves
// to the other requester.
//   clk, rst_n                  : rising-edge clock, async active-low reset
//   a_valid/a_data/a_last/a_ready : requester A beat handshake
//   b_valid/b_data/b_last/b_ready : requester B beat handshake
//   d_valid/d_data/d_last/d_ready : registered output toward the consumer
//   sel                           : registered mux select (0 = A, 1 = B)
//   busy                          : registered, high while A or B owns the path
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [DATAWIDTH-1:0] a_data,
    input  logic                 a_last,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [DATAWIDTH-1:0] b_data,
    input  logic                 b_last,
    output logic                 b_ready,
    output logic                 d_valid,
    output logic [DATAWIDTH-1:0] d_data,
    output logic                 d_last,
    input  logic                 d_ready,
    output logic                 sel,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 d_valid_q, d_valid_d;
    logic [DATAWIDTH-1:0] d_data_q, d_data_d;
    logic                 d_last_q, d_last_d;

    logic [DATAWIDTH-1:0] mux_data;
    logic                 mux_last;
    logic                 accept;
    logic                 reg_free;

    mux2x1 #(.DATAWIDTH(DATAWIDTH)) u_mux_data (
        .sel (sel_q),
        .in0 (a_data),
        .in1 (b_data),
        .out (mux_data)
    );

    mux2x1 #(.DATAWIDTH(1)) u_mux_last (
        .sel (sel_q),
        .in0 (a_last),
        .in1 (b_last),
        .out (mux_last)
    );

    // The register can take a beat when empty or when it drains on this edge.
    assign reg_free = !d_valid_q || d_ready;

    always_comb begin
        a_ready = (state_q == ST_OWN_A) && reg_free;
        b_ready = (state_q == ST_OWN_B) && reg_free;
    end

    // sel_q always equals the owner while a grant is held, so the mux output
    // is the accepted beat whichever requester is active.
    assign accept = (a_valid && a_ready) || (b_valid && b_ready);

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        sel_d     = sel_q;
        d_valid_d = d_valid_q;
        d_data_d  = d_data_q;
        d_last_d  = d_last_q;

        case (state_q)
            ST_IDLE: begin
                if (a_valid && (!b_valid || prio_q == SEL_A)) begin
                    state_d = ST_OWN_A;
                    sel_d   = SEL_A;
                end else if (b_valid) begin
                    state_d = ST_OWN_B;
                    sel_d   = SEL_B;
                end
            end
            ST_OWN_A: begin
                if (accept && mux_last) begin
                    state_d = ST_IDLE;
                    prio_d  = SEL_B;
                end
            end
            ST_OWN_B: begin
                if (accept && mux_last) begin
                    state_d = ST_IDLE;
                    prio_d  = SEL_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new load wins over a drain, so d_valid stays high back to back.
        if (accept) begin
            d_valid_d = 1'b1;
            d_data_d  = mux_data;
            d_last_d  = mux_last;
        end else if (d_ready) begin
            d_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prio_q    <= SEL_A;
            sel_q     <= SEL_A;
            busy_q    <= 1'b0;
            d_valid_q <= 1'b0;
            d_data_q  <= '0;
            d_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            d_valid_q <= d_valid_d;
            d_data_q  <= d_data_d;
            d_last_q  <= d_last_d;
        end
    end

    assign d_valid = d_valid_q;
    assign d_data  = d_data_q;
    assign d_last  = d_last_q;
    assign sel     = sel_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk, rst_n;
    logic          a_valid, a_last, a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid, b_last, b_ready;
    logic [DW-1:0] b_data;
    logic          d_valid, d_last, d_ready;
    logic [DW-1:0] d_data;
    logic          sel, busy;

    mux2_rr_arbiter #(.DATAWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .d_valid(d_valid), .d_data(d_data), .d_last(d_last), .d_ready(d_ready),
        .sel(sel), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    // Producer queues and per-cycle enable of their valid.
    beat_t qa[$];
    beat_t qb[$];
    bit    en_a, en_b;

    // Pre-edge samples captured by drv_cycle.
    bit            pre_rdy_a, pre_rdy_b, exp_rdy_a, exp_rdy_b;
    bit            pre_hs_a, pre_hs_b, pre_drain;
    logic [DW-1:0] pre_dd;
    logic          pre_dl;
    beat_t         pre_beat_a, pre_beat_b;

    // Reference model: who owns the path (-1 nobody, 0 A, 1 B), who is
    // preferred next, and what the one-entry output slot holds.
    int            m_owner;
    bit            m_pref, m_sel, m_dv, m_dl;
    logic [DW-1:0] m_dd;

    function automatic bit m_ready(int who);
        return (m_owner == who) && (!m_dv || d_ready);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_pref = 0; m_sel = 0; m_dv = 0; m_dd = '0; m_dl = 0;
    endtask

    task automatic model_edge();
        bit acc_a, acc_b;
        int start_owner;
        acc_a = a_valid && m_ready(0);
        acc_b = b_valid && m_ready(1);
        start_owner = m_owner;
        if (acc_a || acc_b) begin
            m_dv = 1;
            m_dd = acc_a ? a_data : b_data;
            m_dl = acc_a ? a_last : b_last;
            if (m_dl) begin
                m_owner = -1;
                m_pref  = acc_a;   // after A, B is preferred, and vice versa
            end
        end else if (d_ready) begin
            m_dv = 0;
        end
        if (start_owner == -1) begin
            if (a_valid && b_valid) m_owner = m_pref ? 1 : 0;
            else if (a_valid)       m_owner = 0;
            else if (b_valid)       m_owner = 1;
            if (m_owner != -1) m_sel = (m_owner == 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        a_valid = 0; a_data = '0; a_last = 0;
        b_valid = 0; b_data = '0; b_last = 0;
        en_a = 0; en_b = 0;
        qa.delete(); qb.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
        cyc_n = 0;
    endtask

    // One clock: present queue heads, sample pre-edge handshakes, advance the
    // model with the edge, then retire accepted beats.
    task automatic drv_cycle();
        a_valid = en_a && (qa.size() > 0);
        b_valid = en_b && (qb.size() > 0);
        if (a_valid) begin a_data = qa[0].data; a_last = qa[0].last; end
        else begin a_data = '0; a_last = 0; end
        if (b_valid) begin b_data = qb[0].data; b_last = qb[0].last; end
        else begin b_data = '0; b_last = 0; end
        #1;
        pre_rdy_a = a_ready;   pre_rdy_b = b_ready;
        exp_rdy_a = m_ready(0); exp_rdy_b = m_ready(1);
        pre_hs_a  = a_valid && a_ready;
        pre_hs_b  = b_valid && b_ready;
        pre_drain = d_valid && d_ready;
        pre_dd    = d_data;   pre_dl = d_last;
        @(posedge clk);
        model_edge();
        #1;
        if (pre_hs_a) pre_beat_a = qa.pop_front();
        if (pre_hs_b) pre_beat_b = qb.pop_front();
        cyc_n++;
    endtask

    task automatic test_reset();
        rst_n = 0; d_ready = 1;
        a_valid = 1; a_data = 8'h3C; a_last = 1;
        b_valid = 1; b_data = 8'hC3; b_last = 1;
        #3;
        n_tests++;
        if ({d_valid, d_data, d_last, sel, busy, a_ready, b_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got dv=%b dd=%h dl=%b sel=%b busy=%b ar=%b br=%b want all 0",
                     d_valid, d_data, d_last, sel, busy, a_ready, b_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold got busy=%b ar=%b br=%b want 0 0 0", busy, a_ready, b_ready);
        end
    endtask

    task automatic test_lone();
        logic [DW-1:0] exp_d[3];
        int nb;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        nb = 0;
        do_reset();
        d_ready = 1;
        qa.push_back('{8'h11, 1'b0});
        qa.push_back('{8'h22, 1'b0});
        qa.push_back('{8'h33, 1'b1});
        en_a = 1;
        for (int i = 0; i < 6; i++) begin
            drv_cycle();
            if (d_valid) begin
                n_tests++;
                if (nb >= 3) begin
                    n_fail++;
                    $display("FAIL lone_extra got d_data=%h at cycle %0d want no beat", d_data, cyc_n);
                end else if (cyc_n != nb + 2 || d_data !== exp_d[nb] || d_last !== (nb == 2)) begin
                    n_fail++;
                    $display("FAIL lone_beat%0d got cyc=%0d d=%h l=%b want cyc=%0d d=%h l=%b",
                             nb, cyc_n, d_data, d_last, nb + 2, exp_d[nb], nb == 2);
                end
                nb++;
            end
        end
        n_tests++;
        if (nb != 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_end got beats=%0d busy=%b want 3 0", nb, busy);
        end
        // prio now favours B: a simultaneous request must go to B.
        qa.push_back('{8'h44, 1'b1});
        qb.push_back('{8'h55, 1'b1});
        en_b = 1;
        drv_cycle();
        n_tests++;
        if (sel !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lone_prio got sel=%b busy=%b want 1 1", sel, busy);
        end
    endtask

    task automatic test_contention();
        bit            exp_v[9];
        logic [DW-1:0] exp_d[9];
        do_reset();
        d_ready = 1;
        qa.push_back('{8'hA0, 1'b0}); qa.push_back('{8'hA1, 1'b1});
        qb.push_back('{8'hB0, 1'b0}); qb.push_back('{8'hB1, 1'b1});
        en_a = 1; en_b = 1;
        for (int k = 0; k < 9; k++) begin exp_v[k] = 0; exp_d[k] = '0; end
        exp_v[2] = 1; exp_d[2] = 8'hA0;
        exp_v[3] = 1; exp_d[3] = 8'hA1;
        exp_v[5] = 1; exp_d[5] = 8'hB0;
        exp_v[6] = 1; exp_d[6] = 8'hB1;
        for (int i = 0; i < 8; i++) begin
            drv_cycle();
            if (i <= 2) begin
                n_tests++;
                if (pre_rdy_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_bready cycle %0d got %b want 0", i, pre_rdy_b);
                end
            end
            n_tests++;
            if (d_valid !== exp_v[cyc_n] || (exp_v[cyc_n] && d_data !== exp_d[cyc_n])) begin
                n_fail++;
                $display("FAIL cont_out cycle %0d got v=%b d=%h want v=%b d=%h",
                         cyc_n, d_valid, d_data, exp_v[cyc_n], exp_d[cyc_n]);
            end
            if (cyc_n == 3 || cyc_n == 4) begin
                n_tests++;
                if (busy !== (cyc_n == 4) || (cyc_n == 4 && sel !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL cont_gap cycle %0d got busy=%b sel=%b", cyc_n, busy, sel);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        qa.push_back('{8'h5A, 1'b0});
        qa.push_back('{8'h6B, 1'b1});
        en_a = 1;
        for (int i = 0; i < 9; i++) begin
            d_ready = (i < 2 || i >= 6);
            drv_cycle();
            if (i >= 1 && i <= 5) begin
                n_tests++;
                if (d_valid !== 1'b1 || d_data !== 8'h5A || d_last !== 1'b0 ||
                    (i >= 2 && pre_rdy_a !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL bp_hold cycle %0d got v=%b d=%h l=%b ar=%b want 1 5a 0 0",
                             cyc_n, d_valid, d_data, d_last, pre_rdy_a);
                end
            end
            if (i == 6) begin
                n_tests++;
                if (pre_rdy_a !== 1'b1 || d_valid !== 1'b1 || d_data !== 8'h6B || d_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_next got ar=%b v=%b d=%h l=%b want 1 1 6b 1",
                             pre_rdy_a, d_valid, d_data, d_last);
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        d_ready = 1;
        qa.push_back('{8'hC0, 1'b0}); qa.push_back('{8'hC1, 1'b0}); qa.push_back('{8'hC2, 1'b1});
        qb.push_back('{8'hD0, 1'b1});
        en_b = 1;
        for (int i = 0; i < 10; i++) begin
            en_a = !(i >= 2 && i < 5);
            drv_cycle();
            if (i <= 7) begin
                n_tests++;
                if (pre_rdy_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_bready cycle %0d got %b want 0", i, pre_rdy_b);
                end
            end
            if (cyc_n <= 6) begin
                n_tests++;
                if (busy !== 1'b1 || sel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_own cycle %0d got busy=%b sel=%b want 1 0", cyc_n, busy, sel);
                end
            end
            if (cyc_n == 8) begin
                n_tests++;
                if (busy !== 1'b1 || sel !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lock_grant_b got busy=%b sel=%b want 1 1", busy, sel);
                end
            end
            if (cyc_n == 9) begin
                n_tests++;
                if (d_valid !== 1'b1 || d_data !== 8'hD0 || d_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lock_b_beat got v=%b d=%h l=%b want 1 d0 1", d_valid, d_data, d_last);
                end
            end
        end
    endtask

    task automatic test_alternation();
        logic [DW-1:0] seq[8];
        do_reset();
        d_ready = 1;
        for (int j = 0; j < 4; j++) begin
            qa.push_back('{8'hA0 + DW'(j), 1'b1});
            qb.push_back('{8'hB0 + DW'(j), 1'b1});
            seq[2*j]   = 8'hA0 + DW'(j);
            seq[2*j+1] = 8'hB0 + DW'(j);
        end
        en_a = 1; en_b = 1;
        for (int i = 0; i < 16; i++) begin
            drv_cycle();
            n_tests++;
            if (d_valid !== (cyc_n % 2 == 0) ||
                (cyc_n % 2 == 0 && d_data !== seq[cyc_n/2 - 1])) begin
                n_fail++;
                $display("FAIL alt cycle %0d got v=%b d=%h want v=%b d=%h",
                         cyc_n, d_valid, d_data, cyc_n % 2 == 0,
                         (cyc_n % 2 == 0) ? seq[cyc_n/2 - 1] : 8'h00);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        d_ready = 0;
        qb.push_back('{8'h77, 1'b0}); qb.push_back('{8'h78, 1'b1});
        en_b = 1;
        drv_cycle();
        drv_cycle();
        n_tests++;
        if (d_valid !== 1'b1 || busy !== 1'b1 || sel !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_setup got v=%b busy=%b sel=%b want 1 1 1", d_valid, busy, sel);
        end
        #2;
        rst_n = 0;
        #1;
        n_tests++;
        if ({d_valid, d_data, d_last, sel, busy, a_ready, b_ready} !== '0) begin
            n_fail++;
            $display("FAIL rmid_async got dv=%b dd=%h dl=%b sel=%b busy=%b ar=%b br=%b want all 0",
                     d_valid, d_data, d_last, sel, busy, a_ready, b_ready);
        end
        model_reset();
        qa.delete(); qb.delete();
        rst_n = 1;
        d_ready = 1;
        qa.push_back('{8'hAA, 1'b1});
        qb.push_back('{8'hBB, 1'b1});
        en_a = 1; en_b = 1;
        drv_cycle();
        n_tests++;
        if (sel !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_prio got sel=%b busy=%b want 0 1", sel, busy);
        end
        drv_cycle();
        n_tests++;
        if (d_valid !== 1'b1 || d_data !== 8'hAA) begin
            n_fail++;
            $display("FAIL rmid_first got v=%b d=%h want 1 aa", d_valid, d_data);
        end
    endtask

    task automatic test_random();
        beat_t sb[$];
        beat_t exp_b;
        int    len;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            d_ready = 1;
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) qa.push_back('{DW'($urandom), k == len - 1});
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) qb.push_back('{DW'($urandom), k == len - 1});
            end
            sb.delete();
            for (int c = 0; c < 250; c++) begin
                en_a    = (c >= 150) || ($urandom_range(0, 3) != 0);
                en_b    = (c >= 150) || ($urandom_range(0, 3) != 0);
                d_ready = (c >= 150) || ($urandom_range(0, 2) != 0);
                drv_cycle();
                n_tests++;
                if (pre_rdy_a !== exp_rdy_a || pre_rdy_b !== exp_rdy_b ||
                    d_valid !== m_dv || d_data !== m_dd || d_last !== m_dl ||
                    sel !== m_sel || busy !== (m_owner != -1)) begin
                    n_fail++;
                    $display("FAIL rand r%0d c%0d got ar=%b br=%b v=%b d=%h l=%b sel=%b busy=%b want %b %b %b %h %b %b %b",
                             r, c, pre_rdy_a, pre_rdy_b, d_valid, d_data, d_last, sel, busy,
                             exp_rdy_a, exp_rdy_b, m_dv, m_dd, m_dl, m_sel, m_owner != -1);
                end
                if (pre_drain) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_sb r%0d c%0d got beat %h with nothing pending", r, c, pre_dd);
                    end else begin
                        exp_b = sb.pop_front();
                        if (pre_dd !== exp_b.data || pre_dl !== exp_b.last) begin
                            n_fail++;
                            $display("FAIL rand_sb r%0d c%0d got %h/%b want %h/%b",
                                     r, c, pre_dd, pre_dl, exp_b.data, exp_b.last);
                        end
                    end
                end
                if (pre_hs_a) sb.push_back(pre_beat_a);
                if (pre_hs_b) sb.push_back(pre_beat_b);
            end
            n_tests++;
            if (qa.size() != 0 || qb.size() != 0 || sb.size() != 0) begin
                n_fail++;
                $display("FAIL rand_drain r%0d got left a=%0d b=%0d out=%0d want 0 0 0",
                         r, qa.size(), qb.size(), sb.size());
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lone();
        test_contention();
        test_backpressure();
        test_lock();
        test_alternation();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
